// File: rtl/ctrl7seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment controller:
// segment vector type, blank glyph, brightness width and the hex-to-glyph map.
// Glyphs are active-low, bit order g..a (bit 0 = segment a).
package ctrl7seg_pkg;

    typedef logic [6:0] segmentos_t;

    localparam segmentos_t SEG_APAGADO  = 7'h7F;
    localparam int         ANCHO_BRILLO = 4;

    // Active-low glyph for a hex nibble, 0-9 and A b C d E F
    function automatic segmentos_t hex_a_segmentos(input logic [3:0] nibble);
        segmentos_t seg;
        case (nibble)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/decodificador_hex_7seg.sv
// Combinational nibble to active-low 7-segment glyph decoder.
module decodificador_hex_7seg
    import ctrl7seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_segmentos
);

    // Pure table lookup shared with the package so every user sees one glyph set
    always_comb begin
        o_segmentos = hex_a_segmentos(i_nibble);
    end

endmodule

// File: rtl/controlador_display_7seg_multiplexado.sv
// Multiplexed common-anode 7-segment controller for N_DIGITOS digits with
// frame-synchronous data capture, per-digit decimal points, 16-level PWM
// brightness and a display enable. All outputs are registered.
// Optional feature: define CTRL7SEG_SUPRESION_CEROS_EN to blank leading zeros.
module controlador_display_7seg_multiplexado
    import ctrl7seg_pkg::*;
#(
    parameter int N_DIGITOS = 4,
    parameter int ANCHO_DIV = 16
) (
    input  logic                    i_Reloj,
    input  logic                    i_Reset,
    input  logic [4*N_DIGITOS-1:0]  i_Datos,
    input  logic [N_DIGITOS-1:0]    i_Punto,
    input  logic [ANCHO_BRILLO-1:0] i_Brillo,
    input  logic                    i_Habilitar,
    output logic [6:0]              o_Segmentos,
    output logic                    o_Punto,
    output logic [N_DIGITOS-1:0]    o_Anodo,
    output logic                    o_Inicio_Trama
);

    localparam int                   ANCHO_IDX  = $clog2(N_DIGITOS);
    localparam logic [ANCHO_IDX-1:0] IDX_ULTIMO = ANCHO_IDX'(N_DIGITOS - 1);

    logic [ANCHO_DIV-1:0]   cnt_q, cnt_d;
    logic [ANCHO_IDX-1:0]   idx_q, idx_d;
    logic [4*N_DIGITOS-1:0] datos_q, datos_d;
    logic [N_DIGITOS-1:0]   punto_q, punto_d;
    logic [6:0]             segmentos_q, segmentos_d;
    logic                   punto_sal_q, punto_sal_d;
    logic [N_DIGITOS-1:0]   anodo_q, anodo_d;
    logic                   inicio_q, inicio_d;

    logic                   captura;
    logic [3:0]             nibble_sel;
    logic                   punto_sel;
    logic                   pwm_activo;
    logic [6:0]             glifo;
`ifdef CTRL7SEG_SUPRESION_CEROS_EN
    logic [N_DIGITOS-1:0]   ceros_arriba;
    logic                   ceros_sel;
    logic                   blanco;
`endif

    // Slot/digit scan and shadow capture at the very first slot of each frame
    always_comb begin
        captura = (cnt_q == '0) && (idx_q == '0);
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        if (cnt_q == '1) begin
            idx_d = (idx_q == IDX_ULTIMO) ? '0 : idx_q + 1'b1;
        end
        datos_d = captura ? i_Datos : datos_q;
        punto_d = captura ? i_Punto : punto_q;
    end

    // Select the nibble and point of the scanned digit; reads the post-capture
    // shadow so the frame's first lit cycle already shows the new data
    always_comb begin
        nibble_sel = '0;
        punto_sel  = 1'b0;
        for (int k = 0; k < N_DIGITOS; k++) begin
            if (idx_q == ANCHO_IDX'(k)) begin
                nibble_sel = datos_d[4*k +: 4];
                punto_sel  = punto_d[k];
            end
        end
    end

    decodificador_hex_7seg u_decodificador (
        .i_nibble    (nibble_sel),
        .o_segmentos (glifo)
    );

`ifdef CTRL7SEG_SUPRESION_CEROS_EN
    // A digit is a leading zero when it and every more-significant nibble are zero
    always_comb begin
        ceros_arriba = '0;
        ceros_arriba[N_DIGITOS-1] = (datos_d[4*N_DIGITOS-1 -: 4] == 4'h0);
        for (int k = N_DIGITOS - 2; k >= 0; k--) begin
            ceros_arriba[k] = (datos_d[4*k +: 4] == 4'h0) && ceros_arriba[k+1];
        end
        ceros_sel = 1'b0;
        for (int k = 0; k < N_DIGITOS; k++) begin
            if (idx_q == ANCHO_IDX'(k)) begin
                ceros_sel = ceros_arriba[k];
            end
        end
        blanco = (idx_q != '0) && ceros_sel && !punto_sel;
    end
`endif

    // Next output values: glyph always driven, only the anode is gated by PWM/enable
    always_comb begin
        pwm_activo  = (cnt_q[ANCHO_DIV-1 -: ANCHO_BRILLO] <= i_Brillo);
        segmentos_d = glifo;
`ifdef CTRL7SEG_SUPRESION_CEROS_EN
        if (blanco) begin
            segmentos_d = SEG_APAGADO;
        end
`endif
        punto_sal_d = ~punto_sel;
        anodo_d     = '1;
        if (i_Habilitar && pwm_activo) begin
            for (int k = 0; k < N_DIGITOS; k++) begin
                if (idx_q == ANCHO_IDX'(k)) begin
                    anodo_d[k] = 1'b0;
                end
            end
        end
        inicio_d = captura;
    end

    // State and output registers, asynchronously cleared to the dark display
    always_ff @(posedge i_Reloj or negedge i_Reset) begin
        if (!i_Reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            datos_q     <= '0;
            punto_q     <= '0;
            segmentos_q <= SEG_APAGADO;
            punto_sal_q <= 1'b1;
            anodo_q     <= '1;
            inicio_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            datos_q     <= datos_d;
            punto_q     <= punto_d;
            segmentos_q <= segmentos_d;
            punto_sal_q <= punto_sal_d;
            anodo_q     <= anodo_d;
            inicio_q    <= inicio_d;
        end
    end

    assign o_Segmentos    = segmentos_q;
    assign o_Punto        = punto_sal_q;
    assign o_Anodo        = anodo_q;
    assign o_Inicio_Trama = inicio_q;

endmodule

// File: doc/controlador_display_7seg_multiplexado.md
# controlador_display_7seg_multiplexado

Parametrised successor to the four-digit multiplexed 7-segment controller: drives N_DIGITOS common-anode digits from a packed hex bus with a programmable refresh rate. Adds per-digit decimal points, 16-level PWM brightness, a display enable and frame-synchronous data capture (no tearing). Sits between the datapath that produces the nibbles and the board's segment/anode pins.

## Interface
- N_DIGITOS, 4: number of multiplexed digits (2..8).
- ANCHO_DIV, 16: slot counter width; each digit is lit for 2^ANCHO_DIV cycles per frame (ANCHO_DIV >= 4).
- i_Reloj  in  1  system clock, all logic on rising edge.
- i_Reset  in  1  asynchronous, active-low reset.
- i_Datos  in  4*N_DIGITOS  packed nibbles; [3:0] is digit 0 (rightmost).
- i_Punto  in  N_DIGITOS  decimal-point request per digit, 1 = lit.
- i_Brillo  in  4  brightness, 0 = 1/16 duty, 15 = full duty.
- i_Habilitar  in  1  0 = all digits dark.
- o_Segmentos  out  7  active-low segments, [0]=a ... [6]=g.
- o_Punto  out  1  active-low decimal point.
- o_Anodo  out  N_DIGITOS  active-low anode select, one-hot-low when lit.
- o_Inicio_Trama  out  1  one-cycle pulse at start of each frame.

## Operation
- Slot counter cnt (ANCHO_DIV bits) increments every cycle, wraps 2^ANCHO_DIV-1 -> 0.
- Digit index idx (0..N_DIGITOS-1) advances when cnt wraps; wraps N_DIGITOS-1 -> 0 (non-power-of-two N handled explicitly).
- Shadow capture: when cnt==0 and idx==0, i_Datos and i_Punto load into shadow registers; displayed data come only from shadows. Mid-frame input changes appear next frame.
- Decode: shadow nibble of idx -> hex glyph 0-F; o_Punto = ~shadow point of idx.
- Brightness: anode idx active only while cnt[ANCHO_DIV-1 -: 4] <= i_Brillo (i_Brillo sampled live).
- i_Habilitar=0: o_Anodo all ones; counters and shadow capture continue running.
- Reset (any time, including mid-frame): cnt=0, idx=0, shadows=0, outputs to reset values; first capture occurs on first clock after release.

## Timing
- Reset values: o_Anodo all ones, o_Segmentos 7'h7F, o_Punto 1, o_Inicio_Trama 0.
- All outputs registered: reflect cnt/idx state with exactly 1 cycle latency.
- o_Inicio_Trama high the cycle after the capture cycle (aligned with first lit cycle of digit 0).
- Frame length N_DIGITOS * 2^ANCHO_DIV cycles; no gaps between slots.
- Glyphs (active-low, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 8=0000000, F=0001110.
- Segments of a dark digit (PWM off or disabled) are held at the glyph value; only anodes gate.

## Configuration
- CTRL7SEG_SUPRESION_CEROS_EN defined: digit k > 0 is blanked (o_Segmentos 7'h7F, anode still follows PWM) when its shadow nibble and all more-significant shadow nibbles are zero and its point is 0. Digit 0 never blanked.
- Not defined: every digit shows its glyph, including leading zeros.

## Structure
- Package ctrl7seg_pkg: glyph constants / hex-to-segment function, SEG_APAGADO = 7'h7F, brightness width constant.
- Sub-module decodificador_hex_7seg: combinational nibble -> active-low glyph; instantiated once on the muxed nibble.

## Test plan
- N=4, ANCHO_DIV=4, i_Datos=16'h4321, i_Brillo=15, enable: after reset release o_Anodo cycles 1110,1101,1011,0111 every 16 cycles; segments 1111001, 0100100, 0110000, 0011001.
- Change i_Datos to 16'h8888 at cycle 20 of a frame -> digits keep 4321 until next o_Inicio_Trama, then show 0000000.
- i_Brillo=3 -> each digit anode low for 4 of 16 cycles (cnt 0..3), high for 12.
- i_Datos=16'h0005, i_Punto=4'b0100: with macro, digit 3 blanked (7F), digit 2 shows 1000000 with o_Punto=0; without macro, digits 3..1 show 1000000.
- i_Habilitar=0 for a full frame -> o_Anodo stays 1111; o_Inicio_Trama still pulses every 64 cycles.
- Assert i_Reset low mid-slot of digit 2 -> outputs at reset values asynchronously; after release scan restarts at digit 0 with newly captured data.
